// File: rtl/generate_serializer.sv
// Parallel-to-serial transmitter: loads a BITS-wide word over valid/ready, emits it LSB first with a last flag.
// Define GENERATE_SERIALIZER_ASSERT_EN to compile in the immediate-assertion checkers p0..p3.
module generate_serializer #(
  parameter int BITS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            load_valid,
  output logic            load_ready,
  input  logic [BITS-1:0] data,
  output logic            tx_valid,
  input  logic            tx_ready,
  output logic            tx_bit,
  output logic            tx_last
);

  localparam int IW = (BITS > 1) ? $clog2(BITS) : 1;
  localparam logic [IW-1:0] LAST_IDX = IW'(BITS - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // FSM state and bit index kept together so checkers can bind to one struct.
  typedef struct packed {
    state_t          state;
    logic [IW-1:0]   idx;
  } fsm_t;

  fsm_t            fsm_q;
  logic [BITS-1:0] word_q;
  logic [IW-1:0]   idx_next;
  logic            load_fire;

  // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
  // load_ready and tx_valid are registered and mutually exclusive.
  assign load_fire = load_valid && load_ready;
  assign idx_next  = fsm_q.idx + IW'(1);

  for (genvar i = 0; i < BITS; i = i + 1) begin : slice
    logic bit_q;
    always_ff @(posedge clk) begin
      if (rst) begin
        bit_q <= 1'b0;
      end else if (load_fire) begin
        bit_q <= data[i];
      end
    end
    assign word_q[i] = bit_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q.state <= IDLE;
      fsm_q.idx   <= '0;
      load_ready  <= 1'b1;
      tx_valid    <= 1'b0;
      tx_bit      <= 1'b0;
      tx_last     <= 1'b0;
    end else begin
      case (fsm_q.state)
        IDLE: begin
          if (load_valid) begin
            fsm_q.state <= SHIFT;
            fsm_q.idx   <= '0;
            load_ready  <= 1'b0;
            tx_valid    <= 1'b1;
            // Slices capture on this same edge, so bit 0 comes straight from the input.
            tx_bit      <= data[0];
            tx_last     <= 1'b0;
          end
        end
        SHIFT: begin
          if (tx_ready) begin
            if (fsm_q.idx == LAST_IDX) begin
              fsm_q.state <= IDLE;
              fsm_q.idx   <= '0;
              load_ready  <= 1'b1;
              tx_valid    <= 1'b0;
              tx_bit      <= 1'b0;
              tx_last     <= 1'b0;
            end else begin
              fsm_q.idx   <= idx_next;
              tx_bit      <= word_q[idx_next];
              tx_last     <= (idx_next == LAST_IDX);
            end
          end
        end
        default: begin
          fsm_q.state <= IDLE;
          fsm_q.idx   <= '0;
          load_ready  <= 1'b1;
          tx_valid    <= 1'b0;
          tx_bit      <= 1'b0;
          tx_last     <= 1'b0;
        end
      endcase
    end
  end

`ifdef GENERATE_SERIALIZER_ASSERT_EN
  always @(posedge clk) begin
    if (!rst) begin
      p0: assert (!(tx_valid && load_ready))
        else $error("p0: tx_valid and load_ready both high");
      p1: assert (!tx_last || tx_valid)
        else $error("p1: tx_last without tx_valid");
      p2: assert (fsm_q.idx <= LAST_IDX)
        else $error("p2: idx out of range");
      if (fsm_q.state == SHIFT) begin
        p3: assert (tx_bit == word_q[fsm_q.idx])
          else $error("p3: tx_bit does not match selected slice");
      end
    end
  end
`endif

endmodule
